pmu_counter_bank: RTL and testbench

PMU_COUNTER_BANK -- requirements
Module: pmu_counter_bank

---
 rtl/pmu_counter_bank.sv | 76 +++++++
 tb/tb_pmu_counter_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pmu_counter_bank.sv
// Bank of N_CNT event counters with preload, sticky overflow flags and a masked overflow interrupt.
// Define PMU_COUNTER_SATURATE_EN to make counters stick at all-ones instead of wrapping to zero.
module pmu_counter_bank #(
  parameter int N_CNT = 24,
  parameter int CNT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CNT-1:0]         events_i,
  input  logic [N_CNT-1:0]         en_i,
  input  logic                     clear_i,
  input  logic                     we_i,
  input  logic [$clog2(N_CNT)-1:0] waddr_i,
  input  logic [CNT_W-1:0]         wdata_i,
  input  logic [N_CNT-1:0]         ovf_clr_i,
  input  logic [N_CNT-1:0]         ovf_mask_i,
  output logic [N_CNT*CNT_W-1:0]   counters_o,
  output logic [N_CNT-1:0]         overflow_o,
  output logic                     intr_o
);

  localparam int ADDR_W = $clog2(N_CNT);

  logic [CNT_W-1:0] cnt_q [N_CNT];
  logic [CNT_W-1:0] cnt_next [N_CNT];
  logic [N_CNT-1:0] ovf_q;
  logic [N_CNT-1:0] hit;
  logic [N_CNT-1:0] inc;
  logic [N_CNT-1:0] at_max;
  logic             intr_q;

  // An out-of-range waddr_i matches no index, so such writes are dropped for free.
  always_comb begin
    hit    = '0;
    inc    = '0;
    at_max = '0;
    for (int k = 0; k < N_CNT; k++) begin
      hit[k]      = we_i && (waddr_i == ADDR_W'(k));
      inc[k]      = events_i[k] && en_i[k] && !hit[k];
      at_max[k]   = &cnt_q[k];
`ifdef PMU_COUNTER_SATURATE_EN
      cnt_next[k] = at_max[k] ? cnt_q[k] : cnt_q[k] + CNT_W'(1);
`else
      cnt_next[k] = cnt_q[k] + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int k = 0; k < N_CNT; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < N_CNT; k++) begin
        if (hit[k])      cnt_q[k] <= wdata_i;
        else if (inc[k]) cnt_q[k] <= cnt_next[k];
      end
      // A new overflow beats a simultaneous flag clear.
      ovf_q <= (ovf_q & ~ovf_clr_i) | (inc & at_max);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) intr_q <= 1'b0;
    else       intr_q <= |(ovf_q & ovf_mask_i);
  end

  always_comb begin
    counters_o = '0;
    for (int k = 0; k < N_CNT; k++) counters_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign overflow_o = ovf_q;
  assign intr_o     = intr_q;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Randomised and directed bench for pmu_counter_bank against an integer-arithmetic reference model.
// Honours PMU_COUNTER_SATURATE_EN the same way as the design.
module tb_pmu_counter_bank;

  localparam int N_CNT  = 24;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = $clog2(N_CNT);
  localparam int VW     = N_CNT * CNT_W;
`ifdef PMU_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint unsigned MAXV = (64'd1 << CNT_W) - 64'd1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N_CNT-1:0]  events_i, en_i, ovf_clr_i, ovf_mask_i;
  logic              clear_i, we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [CNT_W-1:0]  wdata_i;
  logic [VW-1:0]     counters_o;
  logic [N_CNT-1:0]  overflow_o;
  logic              intr_o;

  int checks = 0;
  int errors = 0;

  longint unsigned m_cnt [N_CNT];
  bit              m_ovf [N_CNT];
  bit              m_intr;

  pmu_counter_bank #(.N_CNT(N_CNT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .events_i(events_i), .en_i(en_i),
    .clear_i(clear_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .ovf_clr_i(ovf_clr_i), .ovf_mask_i(ovf_mask_i),
    .counters_o(counters_o), .overflow_o(overflow_o), .intr_o(intr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs currently driven.
  task automatic modelStep();
    bit any_pend = 1'b0;
    for (int k = 0; k < N_CNT; k++) if (m_ovf[k] && ovf_mask_i[k]) any_pend = 1'b1;
    m_intr = rst_i ? 1'b0 : any_pend;
    for (int k = 0; k < N_CNT; k++) begin
      if (rst_i || clear_i) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end else begin
        bit newovf = 1'b0;
        if (we_i && int'(waddr_i) == k) m_cnt[k] = longint'(wdata_i);
        else if (events_i[k] && en_i[k]) begin
          if (m_cnt[k] == MAXV) begin
            newovf   = 1'b1;
            m_cnt[k] = SAT ? MAXV : 0;
          end else m_cnt[k] = m_cnt[k] + 1;
        end
        if (newovf) m_ovf[k] = 1'b1;
        else if (ovf_clr_i[k]) m_ovf[k] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus();
    logic [VW-1:0]    exp_cnt;
    logic [N_CNT-1:0] exp_ovf;
    @(posedge clk_i);
    modelStep();
    #1;
    for (int k = 0; k < N_CNT; k++) begin
      exp_cnt[k*CNT_W +: CNT_W] = m_cnt[k][CNT_W-1:0];
      exp_ovf[k] = m_ovf[k];
    end
    checkOutput("model_counters", counters_o, exp_cnt);
    checkOutput("model_overflow", VW'(overflow_o), VW'(exp_ovf));
    checkOutput("model_intr", VW'(intr_o), VW'(m_intr));
  endtask

  task automatic idleInputs();
    rst_i = 0; events_i = '0; en_i = '0; clear_i = 0; we_i = 0;
    waddr_i = '0; wdata_i = '0; ovf_clr_i = '0; ovf_mask_i = '0;
  endtask

  function automatic logic [CNT_W-1:0] cntOf(input int k);
    return counters_o[k*CNT_W +: CNT_W];
  endfunction

  initial begin
    logic [VW-1:0] exp_v;
    idleInputs();
    rst_i = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_counters", counters_o, '0);
    checkOutput("reset_overflow", VW'(overflow_o), '0);
    checkOutput("reset_intr", VW'(intr_o), '0);
    rst_i = 0;

    // Counter 3 counts five events, nobody else moves.
    en_i[3] = 1; events_i[3] = 1;
    repeat (5) applyStimulus();
    exp_v = '0;
    exp_v[3*CNT_W +: CNT_W] = CNT_W'(5);
    checkOutput("cnt3_five", counters_o, exp_v);
    idleInputs();

    // Preload near the top of counter 2 and run across the boundary.
    we_i = 1; waddr_i = ADDR_W'(2); wdata_i = 32'hFFFF_FFFE;
    applyStimulus();
    we_i = 0; en_i[2] = 1; events_i[2] = 1; ovf_mask_i[2] = 1;
    applyStimulus();
    checkOutput("cnt2_ev1", VW'(cntOf(2)), VW'(32'hFFFF_FFFF));
    checkOutput("ovf2_ev1", VW'(overflow_o[2]), VW'(1'b0));
    applyStimulus();
    checkOutput("cnt2_ev2", VW'(cntOf(2)), SAT ? VW'(32'hFFFF_FFFF) : VW'(0));
    checkOutput("ovf2_ev2", VW'(overflow_o[2]), VW'(1'b1));
    checkOutput("intr_same_edge", VW'(intr_o), VW'(1'b0));
    applyStimulus();
    checkOutput("cnt2_ev3", VW'(cntOf(2)), SAT ? VW'(32'hFFFF_FFFF) : VW'(1));
    checkOutput("intr_next_edge", VW'(intr_o), VW'(1'b1));
    idleInputs();
    ovf_clr_i[2] = 1;
    applyStimulus();
    ovf_clr_i[2] = 0;
    applyStimulus();
    checkOutput("intr_after_clr", VW'(intr_o), VW'(1'b0));

    // Preload vs event on counter 5, counter 6 counts alongside.
    we_i = 1; waddr_i = ADDR_W'(5); wdata_i = 32'h100;
    en_i[5] = 1; events_i[5] = 1; en_i[6] = 1; events_i[6] = 1;
    applyStimulus();
    checkOutput("preload5_exact", VW'(cntOf(5)), VW'(32'h100));
    checkOutput("cnt6_parallel", VW'(cntOf(6)), VW'(1));
    idleInputs();

    // Overflow on counter 1 together with its flag clear: set wins.
    we_i = 1; waddr_i = ADDR_W'(1); wdata_i = 32'hFFFF_FFFF;
    applyStimulus();
    we_i = 0; en_i[1] = 1; events_i[1] = 1; ovf_clr_i[1] = 1;
    applyStimulus();
    checkOutput("ovf1_set_wins", VW'(overflow_o[1]), VW'(1'b1));
    en_i[1] = 0; events_i[1] = 0;
    applyStimulus();
    checkOutput("ovf1_cleared", VW'(overflow_o[1]), VW'(1'b0));
    idleInputs();

    // Global clear overrides a preload and events.
    en_i = '1; events_i = '1;
    applyStimulus();
    clear_i = 1; we_i = 1; waddr_i = ADDR_W'(4); wdata_i = 32'h1234;
    applyStimulus();
    checkOutput("clear_counters", counters_o, '0);
    checkOutput("clear_overflow", VW'(overflow_o), '0);
    idleInputs();

    // Mid-count reset pulse, then an out-of-range write.
    en_i = '1; events_i = 24'h0F0F0F;
    repeat (3) applyStimulus();
    rst_i = 1; we_i = 1; waddr_i = ADDR_W'(7); wdata_i = 32'hABCD;
    applyStimulus();
    checkOutput("rst_counters", counters_o, '0);
    checkOutput("rst_overflow", VW'(overflow_o), '0);
    checkOutput("rst_intr", VW'(intr_o), '0);
    idleInputs();
    we_i = 1; waddr_i = ADDR_W'(N_CNT); wdata_i = 32'hDEAD_BEEF;
    applyStimulus();
    checkOutput("oob_write", counters_o, '0);
    idleInputs();

    // Random traffic; preloads favour values near all-ones to provoke overflows.
    for (int i = 0; i < 400; i++) begin
      rst_i      = ($urandom_range(0, 99) == 0);
      clear_i    = ($urandom_range(0, 79) == 0);
      events_i   = N_CNT'($urandom);
      en_i       = N_CNT'($urandom) | N_CNT'($urandom);
      we_i       = ($urandom_range(0, 2) == 0);
      waddr_i    = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      wdata_i    = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFFF - CNT_W'($urandom_range(0, 3))) : CNT_W'($urandom);
      ovf_clr_i  = N_CNT'($urandom) & N_CNT'($urandom) & N_CNT'($urandom);
      ovf_mask_i = N_CNT'($urandom);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
